mdu_hilo: RTL
=============

// Module: mdu_hilo
// PURPOSE
//  Multiply/divide unit plus architectural HI/LO registers for the MIPS EX stage. Sits beside the ALU.
//  Executes MULT/MULTU/DIV/DIVU as multi-cycle ops with a start/busy/done handshake.
//  Owns the only HI/LO storage: takes MTHI/MTLO writes and drives hi/lo for MFHI/MFLO forwarding.
// PARAMETERS
//  WIDTH  32  operand width; the HI/LO result is 2*WIDTH split into hi/lo
// PORTS
//  clk      in   1   clock; every register updates on the posedge
//  resetn   in   1   reset, synchronous, active-low
//  start    in   1   launch op with A/B; accepted only in IDLE and only without flush
//  op       in   2   0=MULT 1=MULTU 2=DIV 3=DIVU; codes are `MDU_* in head.vh
//  A        in   32  rs operand (multiplicand/dividend)
//  B        in   32  rt operand (multiplier/divisor)
//  flush    in   1   exception/ERET cancel; aborts any in-flight op
//  hi_we    in   1   MTHI write strobe
//  lo_we    in   1   MTLO write strobe
//  wdata    in   32  MTHI/MTLO data
//  busy     out  1   op in flight (MUL/DIV/DONE); the pipeline stalls EX on busy
//  done     out  1   1-cycle pulse in the DONE state
//  hi       out  32  HI register
//  lo       out  32  LO register
// BEHAVIOUR
//  - Reset (resetn=0 at posedge): state=IDLE, hi=lo=0, busy=0, done=0; any op in flight is discarded.
//  - FSM IDLE->MUL|DIV on accepted start; MUL|DIV->DONE after the last iteration; DONE->IDLE.
//    flush in MUL/DIV/DONE forces IDLE on the next edge.
//  - Cycle 0 = start-accepted edge: operand magnitudes, result sign and signed flag are latched.
//  - DIV/DIVU: radix-2 restoring, 32 iterations (cycles 1..32). done=1 in cycle 33.
//    HI/LO commit on the edge that ends cycle 33; new values are visible from cycle 34.
//  - MULT/MULTU: iterative shift-add, same 32+1 timing.
//  - Signed ops run on magnitudes, then fix the sign:
//    LO(quot)/product negated if A[31]^B[31]; HI(rem) takes the sign of A.
//    -2^31 magnitude handled in 33-bit form, no overflow trap.
//    MULT/DIV never raise IntegerOverflow.
//  - Divide by zero: no exception. Result is HI=A, LO=0xFFFFFFFF (unsigned core result), for DIV and DIVU.
//  - flush: in any cycle up to and including DONE, the commit is suppressed, hi/lo stay unchanged,
//    done drops next cycle. flush together with start: the start is dropped.
//  - hi_we/lo_we: honoured only in IDLE, on the next edge; ignored while busy.
//    If they coincide with an accepted start, the write takes effect and the later commit overwrites it.
//  - start while busy: ignored. No queueing.
//  - busy is combinational from state (state != IDLE); it rises in cycle 1.
//  - done is registered from state (state == DONE).
// CONFIGURATION
//  MDU_FAST_MUL_EN defined: MULT/MULTU use one registered 33x33 signed multiply.
//    MUL lasts 1 cycle, done=1 in cycle 2, commit at end of cycle 2. Divide is unchanged.
//  MDU_FAST_MUL_EN undefined: iterative multiply, 32+1 timing as for divide.
// STRUCTURE
//  head.vh: `MDU_MULT/`MDU_MULTU/`MDU_DIV/`MDU_DIVU op codes, FSM state encodings.
//  Sub-module mdu_div_iter: restoring divider core.
//    Inputs: load, dividend/divisor magnitudes. Outputs: quot, rem, last.
//  Top level: FSM, sign fix-up, iterative multiplier datapath, HI/LO registers.
// TESTING
//  1. MULT A=0xFFFFFFFE B=3 -> done in cycle 33 (cycle 2 with FAST); HI=0xFFFFFFFF LO=0xFFFFFFFA.
//  2. DIVU A=100 B=7 -> busy cycles 1..33, done only in cycle 33; LO=14 HI=2.
//  3. DIV A=0xFFFFFFF9(-7) B=2 -> LO=0xFFFFFFFD HI=0xFFFFFFFF.
//     DIV A=0x80000000 B=0xFFFFFFFF -> LO=0x80000000 HI=0.
//  4. DIVU A=5 B=0 -> HI=5 LO=0xFFFFFFFF, no exception.
//  5. hi=0x1234, DIV started, flush in cycle 10 -> IDLE and busy=0 in cycle 11; done never pulses; hi=0x1234.
//     Repeat with flush in cycle 33 -> no commit.
//  6. IDLE, hi_we=1 wdata=0xAA with start(MULTU 2*3) -> hi=0xAA in cycle 1, HI=0 LO=6 after commit.
//     start and hi_we during busy -> both ignored. resetn=0 mid-op -> hi=lo=0, IDLE.

Source files
------------

// File: rtl/mdu_hilo_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states and
// small op-decode helpers.
package mdu_hilo_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'd0,
        MDU_MULTU = 2'd1,
        MDU_DIV   = 2'd2,
        MDU_DIVU  = 2'd3
    } mdu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_t;

    function automatic logic op_is_div(input mdu_op_t o);
        return (o == MDU_DIV) || (o == MDU_DIVU);
    endfunction

    function automatic logic op_is_signed(input mdu_op_t o);
        return (o == MDU_MULT) || (o == MDU_DIV);
    endfunction

endpackage

// File: rtl/mdu_hilo_div_iter.sv
// Radix-2 restoring divider core on unsigned magnitudes. One quotient bit per
// cycle after load; last flags the cycle whose edge produces the final bit.
// Divide by zero yields quot = all ones, rem = dividend.
module mdu_div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             last
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] q, r, d;
    logic [CW-1:0]    cnt;
    logic             run;
    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   diff;

    // Trial subtraction of the divisor from the shifted partial remainder
    always_comb begin
        r_sh = {r, q[WIDTH-1]};
        diff = r_sh - {1'b0, d};
    end

    assign last = run && (cnt == CW'(WIDTH - 1));
    assign quot = q;
    assign rem  = r;

    // Iteration register: load operands, then shift/subtract until the last bit
    always_ff @(posedge clk) begin
        if (!resetn) begin
            run <= 1'b0;
        end else if (load) begin
            q   <= dividend;
            r   <= '0;
            d   <= divisor;
            cnt <= '0;
            run <= 1'b1;
        end else if (run) begin
            if (!diff[WIDTH]) begin
                r <= diff[WIDTH-1:0];
                q <= {q[WIDTH-2:0], 1'b1};
            end else begin
                r <= r_sh[WIDTH-1:0];
                q <= {q[WIDTH-2:0], 1'b0};
            end
            cnt <= cnt + 1'b1;
            if (last)
                run <= 1'b0;
        end
    end

endmodule

// File: rtl/mdu_hilo.sv
// MIPS EX-stage multiply/divide unit with the architectural HI/LO registers.
// Optional macro MDU_FAST_MUL_EN: MULT/MULTU use a single registered 33x33
// multiply (done in cycle 2) instead of the 32-step shift-add loop.
module mdu_hilo
    import mdu_hilo_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mdu_state_t state, state_next;

    logic             accept, op_signed, div_last;
    logic [WIDTH-1:0] mag_a, mag_b, quot, rem;
    logic [WIDTH-1:0] res_hi, res_lo;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] mcand;
    logic             is_div, neg_lo, neg_hi;

    assign accept    = (state == ST_IDLE) && start && !flush;
    assign op_signed = op_is_signed(mdu_op_t'(op));
    assign busy      = (state != ST_IDLE);

    // Operand magnitudes; -2^WIDTH-1 maps onto itself as an unsigned magnitude
    always_comb begin
        mag_a = (op_signed && A[WIDTH-1]) ? ('0 - A) : A;
        mag_b = (op_signed && B[WIDTH-1]) ? ('0 - B) : B;
    end

    // The divider is loaded for every op; its last flag also paces the iterative multiply
    mdu_div_iter #(.WIDTH(WIDTH)) u_div (
        .clk      (clk),
        .resetn   (resetn),
        .load     (accept),
        .dividend (mag_a),
        .divisor  (mag_b),
        .quot     (quot),
        .rem      (rem),
        .last     (div_last)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!resetn)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept)
                         state_next = op_is_div(mdu_op_t'(op)) ? ST_DIV : ST_MUL;
`ifdef MDU_FAST_MUL_EN
            ST_MUL:  state_next = flush ? ST_IDLE : ST_DONE;
`else
            ST_MUL:  if (flush) state_next = ST_IDLE;
                     else if (div_last) state_next = ST_DONE;
`endif
            ST_DIV:  if (flush) state_next = ST_IDLE;
                     else if (div_last) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // done is high for exactly the cycle spent in DONE
    always_ff @(posedge clk) begin
        if (!resetn)
            done <= 1'b0;
        else
            done <= (state_next == ST_DONE);
    end

    // Op attributes captured at the accepting edge
    always_ff @(posedge clk) begin
        if (accept) begin
            is_div <= op_is_div(mdu_op_t'(op));
            neg_lo <= op_signed && (A[WIDTH-1] ^ B[WIDTH-1])
                      && !(op_is_div(mdu_op_t'(op)) && (B == '0));
            neg_hi <= op_signed && A[WIDTH-1];
        end
    end

`ifdef MDU_FAST_MUL_EN
    logic signed [WIDTH:0]     fa, fb;
    logic signed [2*WIDTH-1:0] fp;
    always_comb begin
        fa = $signed({1'b0, prod[WIDTH-1:0]});
        fb = $signed({1'b0, mcand});
        fp = (2*WIDTH)'(fa) * (2*WIDTH)'(fb);
    end
`else
    logic [WIDTH:0] add_sum;
    always_comb begin
        add_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    end
`endif

    // Multiplier datapath: multiplier sits in prod's low half and shifts out
    always_ff @(posedge clk) begin
        if (accept) begin
            prod  <= {{WIDTH{1'b0}}, mag_a};
            mcand <= mag_b;
        end else if (state == ST_MUL) begin
`ifdef MDU_FAST_MUL_EN
            prod <= fp;
`else
            prod <= {add_sum, prod[WIDTH-1:1]};
`endif
        end
    end

    // Sign fix-up of the unsigned core result
    always_comb begin
        if (is_div) begin
            res_lo = neg_lo ? ('0 - quot) : quot;
            res_hi = neg_hi ? ('0 - rem) : rem;
        end else begin
            {res_hi, res_lo} = neg_lo ? ('0 - prod) : prod;
        end
    end

    // HI/LO: commit on leaving DONE unless flushed; MTHI/MTLO only while idle
    always_ff @(posedge clk) begin
        if (!resetn) begin
            hi <= '0;
            lo <= '0;
        end else if (state == ST_DONE) begin
            if (!flush) begin
                hi <= res_hi;
                lo <= res_lo;
            end
        end else if (state == ST_IDLE) begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
        end
    end

endmodule
